// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder: control tokens,
// disparity counter width, popcount and the colour-bar table.
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    typedef enum logic [2:0] {
        BAR_WHITE,
        BAR_YELLOW,
        BAR_CYAN,
        BAR_GREEN,
        BAR_MAGENTA,
        BAR_RED,
        BAR_BLUE,
        BAR_BLACK
    } bar_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

    // Returns {R,G,B}; every component is fully on or fully off.
    function automatic logic [23:0] bar_colour(input bar_e bar);
        logic [23:0] rgb;
        case (bar)
            BAR_WHITE:   rgb = 24'hFFFFFF;
            BAR_YELLOW:  rgb = 24'hFFFF00;
            BAR_CYAN:    rgb = 24'h00FFFF;
            BAR_GREEN:   rgb = 24'h00FF00;
            BAR_MAGENTA: rgb = 24'hFF00FF;
            BAR_RED:     rgb = 24'hFF0000;
            BAR_BLUE:    rgb = 24'h0000FF;
            default:     rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: stage 1 transition-minimises the byte, stage 2 DC-balances
// it against the running disparity or emits a control token during blanking.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic       i_clk_pixel,
    input  logic       i_rstn,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic       de,
    output logic [9:0] q
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        n1_d     = popcount8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
    end

    logic [8:0] qm_r;
    logic [3:0] n1q;
    logic [3:0] n0q;
    logic       de_r;
    logic [1:0] c_r;

    // NOTE: every pipeline register sits on the async reset so the outputs
    // drop to zero the moment i_rstn falls, not at the next clock edge.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            qm_r <= '0;
            n1q  <= '0;
            n0q  <= '0;
            de_r <= 1'b0;
            c_r  <= '0;
        end else begin
            qm_r <= qm;
            n1q  <= popcount8(qm[7:0]);
            n0q  <= popcount8(~qm[7:0]);
            de_r <= de;
            c_r  <= c;
        end
    end

    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nxt;
    logic signed [CNT_W-1:0] diff;
    logic [9:0]              q_nxt;

    // Popcounts are zero-extended so the difference is a true signed value.
    always_comb begin
        diff    = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
        q_nxt   = ctrl_token(c_r);
        cnt_nxt = '0;
        if (de_r) begin
            if (cnt == 0 || n1q == n0q) begin
                q_nxt   = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
                cnt_nxt = qm_r[8] ? cnt + diff : cnt - diff;
            end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
                q_nxt   = {1'b1, qm_r[8], ~qm_r[7:0]};
                cnt_nxt = cnt + (qm_r[8] ? TWO : '0) - diff;
            end else begin
                q_nxt   = {1'b0, qm_r[8], qm_r[7:0]};
                cnt_nxt = cnt + diff - (qm_r[8] ? '0 : TWO);
            end
        end
    end

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: RGB888 + syncs in, three 10-bit words out, 2-cycle latency.
// Optional colour-bar generator is compiled in with DVI_TEST_PATTERN_EN.
module dvi_tmds_encoder
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 1024
) (
    input  logic        i_clk_pixel,
    input  logic        i_rstn,
    input  logic [23:0] i_video_data,
    input  logic        i_video_vde,
    input  logic        i_video_hsync,
    input  logic        i_video_vsync,
`ifdef DVI_TEST_PATTERN_EN
    input  logic        i_pattern_en,
`endif
    output logic [9:0]  o_tmds_ch0,
    output logic [9:0]  o_tmds_ch1,
    output logic [9:0]  o_tmds_ch2,
    output logic        o_tmds_vde
);

    // Bars are H_ACTIVE/8 wide, so the line must split evenly.
    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of 8");
    end

    logic [23:0] pix;

`ifdef DVI_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] col;
    logic [10:0] bar_full;
    bar_e        bar;

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) col <= '0;
        else         col <= i_video_vde ? col + 11'd1 : '0;
    end

    // Columns beyond the active width fall into the last (black) bar.
    always_comb begin
        bar_full = col / BAR_W;
        bar      = (bar_full > 11'd7) ? BAR_BLACK : bar_e'(bar_full[2:0]);
        pix      = i_pattern_en ? bar_colour(bar) : i_video_data;
    end
`else
    assign pix = i_video_data;
`endif

    logic [1:0] vde_pipe;

    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) vde_pipe <= '0;
        else         vde_pipe <= {vde_pipe[0], i_video_vde};
    end

    assign o_tmds_vde = vde_pipe[1];

    tmds_channel_encoder u_ch0 (
        .i_clk_pixel (i_clk_pixel),
        .i_rstn      (i_rstn),
        .d           (pix[7:0]),
        .c           ({i_video_vsync, i_video_hsync}),
        .de          (i_video_vde),
        .q           (o_tmds_ch0)
    );

    tmds_channel_encoder u_ch1 (
        .i_clk_pixel (i_clk_pixel),
        .i_rstn      (i_rstn),
        .d           (pix[15:8]),
        .c           (2'b00),
        .de          (i_video_vde),
        .q           (o_tmds_ch1)
    );

    tmds_channel_encoder u_ch2 (
        .i_clk_pixel (i_clk_pixel),
        .i_rstn      (i_rstn),
        .d           (pix[23:16]),
        .c           (2'b00),
        .de          (i_video_vde),
        .q           (o_tmds_ch2)
    );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder against a word-level TMDS model;
// the colour-bar scenario is included when DVI_TEST_PATTERN_EN is defined.
module tb_dvi_tmds_encoder;

    typedef struct packed {
        logic [9:0] ch0;
        logic [9:0] ch1;
        logic [9:0] ch2;
        logic       vde;
    } out_t;

    localparam out_t TOKENS = '{ch0: 10'h354, ch1: 10'h354, ch2: 10'h354, vde: 1'b0};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] data = '0;
    logic        vde = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        pattern_en = 1'b0;
    logic [9:0]  o_tmds_ch0;
    logic [9:0]  o_tmds_ch1;
    logic [9:0]  o_tmds_ch2;
    logic        o_tmds_vde;

    always #5 clk = ~clk;

    dvi_tmds_encoder #(.H_ACTIVE(1024)) dut (
        .i_clk_pixel   (clk),
        .i_rstn        (rstn),
        .i_video_data  (data),
        .i_video_vde   (vde),
        .i_video_hsync (hsync),
        .i_video_vsync (vsync),
`ifdef DVI_TEST_PATTERN_EN
        .i_pattern_en  (pattern_en),
`endif
        .o_tmds_ch0    (o_tmds_ch0),
        .o_tmds_ch1    (o_tmds_ch1),
        .o_tmds_ch2    (o_tmds_ch2),
        .o_tmds_vde    (o_tmds_vde)
    );

    int    tests_run = 0;
    int    fails = 0;
    string cur_test = "none";

    logic [9:0]  tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Model state: expected words for the two in-flight pixels, running disparity, column.
    out_t exp1 = '0;
    out_t exp2 = '0;
    int   cnt_m [3] = '{0, 0, 0};
    int   col_m = 0;
    int   disp [3] = '{0, 0, 0};
    bit   chk_disp = 1'b0;

    // Word-level reference: q_m as prefix parity, then invert so the running
    // disparity (ones minus zeros of emitted words) moves toward zero.
    function automatic logic [9:0] ref_word(input int ch, input logic [7:0] d,
                                            input logic de, input logic [1:0] c);
        int         n1;
        int         n1q;
        logic [8:0] qm;
        logic       inv;
        logic [9:0] w;
        if (!de) begin
            cnt_m[ch] = 0;
            return tok[c];
        end
        n1    = $countones(d);
        qm[8] = !(n1 > 4 || (n1 == 4 && !d[0]));
        for (int i = 0; i < 8; i++)
            qm[i] = (^(d & 8'((1 << (i + 1)) - 1))) ^ (!qm[8] && (i % 2 == 1));
        n1q = $countones(qm[7:0]);
        if (cnt_m[ch] == 0 || n1q == 4) inv = !qm[8];
        else                            inv = ((cnt_m[ch] > 0) == (n1q > 4));
        w = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        cnt_m[ch] += 2 * $countones(w) - 10;
        return w;
    endfunction

    // One pixel period: check outputs at the falling edge, then drive the next inputs.
    task automatic cycle(input logic [23:0] d, input logic de, input logic hs,
                         input logic vs, input logic rst_v, input logic pat);
        out_t        want;
        out_t        got;
        logic [23:0] pix;
        logic [9:0]  w [3];
        @(negedge clk);
        want = rstn ? exp2 : out_t'(0);
        got  = '{ch0: o_tmds_ch0, ch1: o_tmds_ch1, ch2: o_tmds_ch2, vde: o_tmds_vde};
        tests_run++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got ch0=%h ch1=%h ch2=%h vde=%b, want ch0=%h ch1=%h ch2=%h vde=%b",
                     cur_test, got.ch0, got.ch1, got.ch2, got.vde,
                     want.ch0, want.ch1, want.ch2, want.vde);
        end
        if (chk_disp) begin
            w = '{o_tmds_ch0, o_tmds_ch1, o_tmds_ch2};
            for (int ch = 0; ch < 3; ch++) begin
                if (rstn && o_tmds_vde === 1'b1) begin
                    disp[ch] += 2 * $countones(w[ch]) - 10;
                    tests_run++;
                    if (disp[ch] < -10 || disp[ch] > 10) begin
                        fails++;
                        $display("FAIL %s disparity ch%0d: got %0d, want within -10..10",
                                 cur_test, ch, disp[ch]);
                    end
                end else begin
                    disp[ch] = 0;
                end
            end
        end
        rstn  = rst_v;
        data  = d;
        vde   = de;
        hsync = hs;
        vsync = vs;
        pattern_en = pat;
        if (!rst_v) begin
            cnt_m = '{0, 0, 0};
            col_m = 0;
            exp1  = TOKENS;
            exp2  = TOKENS;
        end else begin
            pix = d;
`ifdef DVI_TEST_PATTERN_EN
            if (pat) pix = bar_rgb[(col_m / 128 > 7) ? 7 : col_m / 128];
`endif
            col_m = de ? col_m + 1 : 0;
            exp2 = exp1;
            exp1.ch0 = ref_word(0, pix[7:0], de, {vs, hs});
            exp1.ch1 = ref_word(1, pix[15:8], de, 2'b00);
            exp1.ch2 = ref_word(2, pix[23:16], de, 2'b00);
            exp1.vde = de;
        end
    endtask

    task automatic check_words(input string name, input logic [9:0] w0,
                               input logic [9:0] w1, input logic [9:0] w2);
        tests_run++;
        if ({o_tmds_ch0, o_tmds_ch1, o_tmds_ch2} !== {w0, w1, w2}) begin
            fails++;
            $display("FAIL %s: got %h %h %h, want %h %h %h", name,
                     o_tmds_ch0, o_tmds_ch1, o_tmds_ch2, w0, w1, w2);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        for (int i = 0; i < 5; i++)
            cycle($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_blanking();
        cur_test = "blanking";
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++)
                cycle($urandom, 1'b0, c[0], c[1], 1'b1, 1'b0);
            check_words("blanking_token", tok[c], 10'h354, 10'h354);
        end
    endtask

    task automatic test_dc_balance();
        cur_test = "dc_balance";
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_words("dc_pixel0", 10'h100, 10'h100, 10'h100);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_words("dc_pixel1", 10'h3FF, 10'h3FF, 10'h3FF);
        cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_words("dc_pixel2", 10'h100, 10'h100, 10'h100);
    endtask

    task automatic test_random_frame();
        cur_test = "random_frame";
        chk_disp = 1'b1;
        for (int line = 0; line < 16; line++) begin
            for (int i = 0; i < 8; i++)
                cycle($urandom, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < 96; i++)
                cycle($urandom, 1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_disp = 1'b0;
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        for (int i = 0; i < 300; i++)
            cycle($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        cur_test = "mid_reset";
        for (int i = 0; i < 40; i++)
            cycle($urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_words("mid_reset_async", 10'h000, 10'h000, 10'h000);
        tests_run++;
        if (o_tmds_vde !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_vde: got %b, want 0", o_tmds_vde);
        end
        for (int i = 0; i < 3; i++) cycle($urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) cycle($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

`ifdef DVI_TEST_PATTERN_EN
    task automatic test_pattern();
        cur_test = "pattern";
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cycle($urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 2) check_words("pattern_first_white", 10'h200, 10'h200, 10'h200);
        end
        cur_test = "pattern_switch";
        for (int i = 0; i < 100; i++)
            cycle($urandom, 1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
        for (int i = 0; i < 4; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_blanking();
        test_dc_balance();
        test_random_frame();
        test_back_to_back();
        test_mid_reset();
`ifdef DVI_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
